operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
- Register-read pipeline stage placed directly downstream of the 8x16 register file.
- Drives the register file read addresses (Rs1, Rs2) from the decoded instruction.
- Consumes Rd1/Rd2 and applies write-port bypass. Operands are written once per instruction; a held entry is later refreshed only by a matching writeback (see Behaviour).
- Stalls on load-use hazards and presents a valid/ready-registered operand bundle to the ALU stage.

Parameters:
n, 16, data width (matches register file)
addr_size, 3, register address width
opw, 5, opcode field width

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage accepts instruction this cycle
in_rs1  input  addr_size  source register A
in_rs2  input  addr_size  source register B
in_rd  input  addr_size  destination register
in_op  input  opw  opcode, passed through
in_imm  input  n  immediate
in_use_imm  input  1  operand B = immediate instead of register
Rs1  output  addr_size  register file read address 1 (= in_rs1, combinational)
Rs2  output  addr_size  register file read address 2 (= in_rs2, combinational)
Rd1  input  n  register file read data 1
Rd2  input  n  register file read data 2
wb_we  input  1  writeback enable (same signal as register file WE)
wb_rw  input  addr_size  writeback address
wb_wdata  input  n  writeback data
ex_load_pending  input  1  load in EX whose result is not yet available
ex_load_rd  input  addr_size  destination of that load
out_valid  output  1  operand bundle valid
out_ready  input  1  ALU stage accepts bundle
out_a  output  n  operand A
out_b  output  n  operand B (immediate or register)
out_sdata  output  n  raw register B value (store data)
out_op  output  opw  opcode
out_rd  output  addr_size  destination register
stall_cnt  output  16  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, nReset=0): out_valid=0; out_a, out_b, out_sdata, stall_cnt=0; out_op=0; out_rd=0; internal held rs1/rs2/use_imm=0. Takes effect immediately, mid-operation included; the in-flight bundle is discarded.
- Bypass: srcA = (wb_we && wb_rw==in_rs1) ? wb_wdata : Rd1; srcB same using in_rs2/Rd2. This covers a same-cycle write and read, where the register file still returns the old value.
- hazard = in_valid && ex_load_pending && (ex_load_rd==in_rs1 || (ex_load_rd==in_rs2 && !in_use_imm)). Hazard applies to stores too: if in_use_imm=1, rs2 is not checked even if out_sdata is used.
- in_ready = !hazard && (!out_valid || out_ready). Combinational; no dependence on in_valid except via hazard.
- Capture when in_valid && in_ready. On the next edge:
  - out_valid=1; out_a=srcA; out_sdata=srcB; out_b = in_use_imm ? in_imm : srcB.
  - out_op, out_rd and held rs1/rs2/use_imm are loaded.
  - Latency is 1 cycle from acceptance to out_valid.
- Drain: out_valid && out_ready && no capture -> out_valid=0 at the next edge. Capture and drain in the same cycle -> the new bundle replaces the old one (full throughput, 1 instruction per cycle).
- Hazard cycle with out_ready=1 (or out_valid=0): a bubble is inserted, out_valid=0.
- Hold refresh: while out_valid && !out_ready, if wb_we:
  - wb_rw==held rs1 -> out_a <= wb_wdata.
  - wb_rw==held rs2 -> out_sdata <= wb_wdata, and out_b <= wb_wdata when held use_imm=0.
  - Both may update in the same cycle.
- stall_cnt increments by 1 on each cycle with hazard=1 and saturates at 16'hFFFF. Cleared only by reset.
- A write to a register the stage does not read has no effect.

Test Plan:
- Simple pass: regs r1=0x1234, r2=0x00FF; in rs1=1, rs2=2, op=3, rd=4, use_imm=0, out_ready=1 -> next cycle out_valid=1, out_a=0x1234, out_b=0x00FF, out_rd=4, out_op=3.
- Same-cycle bypass: wb_we=1, wb_rw=1, wb_wdata=0xBEEF while rs1=1 is accepted (register file Rd1 still old 0x1234) -> out_a=0xBEEF.
- Load-use: ex_load_pending=1, ex_load_rd=2, in rs2=2, use_imm=0 for 3 cycles -> in_ready=0 and out_valid=0 for those 3 cycles, stall_cnt=3; release -> accepted next cycle. Repeat with use_imm=1, in_imm=0x0005 -> no stall, out_b=0x0005.
- Backpressure refresh: bundle held with rs1=5, out_ready=0; wb_we=1, wb_rw=5, wb_wdata=0x7777 -> out_a=0x7777 next cycle while out_valid stays 1 and in_ready=0; then out_ready=1 -> bundle consumed once, and out_valid returns to 0 if no new input.
- Back-to-back: 4 instructions with in_valid=1 and out_ready=1 continuously -> 4 consecutive out_valid cycles in order, no bubbles.
- Reset mid-operation: out_valid=1, stall_cnt=7, drop nReset between edges -> out_valid=0, stall_cnt=0, and all data outputs are 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Register-read stage between the 8x16 register file and the ALU: bypasses the write port,
// stalls on load-use hazards and holds a registered operand bundle under valid/ready.
module operand_fetch_stage #(
    parameter int n         = 16,
    parameter int addr_size = 3,
    parameter int opw       = 5
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [addr_size-1:0] in_rs1,
    input  logic [addr_size-1:0] in_rs2,
    input  logic [addr_size-1:0] in_rd,
    input  logic [opw-1:0]       in_op,
    input  logic [n-1:0]         in_imm,
    input  logic                 in_use_imm,
    output logic [addr_size-1:0] Rs1,
    output logic [addr_size-1:0] Rs2,
    input  logic [n-1:0]         Rd1,
    input  logic [n-1:0]         Rd2,
    input  logic                 wb_we,
    input  logic [addr_size-1:0] wb_rw,
    input  logic [n-1:0]         wb_wdata,
    input  logic                 ex_load_pending,
    input  logic [addr_size-1:0] ex_load_rd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [n-1:0]         out_a,
    output logic [n-1:0]         out_b,
    output logic [n-1:0]         out_sdata,
    output logic [opw-1:0]       out_op,
    output logic [addr_size-1:0] out_rd,
    output logic [15:0]          stall_cnt
);

    // Handshake: a transfer happens on any edge where valid && ready are both high;
    // valid never depends on ready, and a held bundle stays stable except for writeback refresh.

    logic                 valid_q, valid_d;
    logic [n-1:0]         a_q, a_d;
    logic [n-1:0]         b_q, b_d;
    logic [n-1:0]         sdata_q, sdata_d;
    logic [opw-1:0]       op_q, op_d;
    logic [addr_size-1:0] rd_q, rd_d;
    logic [addr_size-1:0] rs1_q, rs1_d;
    logic [addr_size-1:0] rs2_q, rs2_d;
    logic                 use_imm_q, use_imm_d;
    logic [15:0]          cnt_q, cnt_d;

    logic         hazard;
    logic         capture;
    logic [n-1:0] src_a;
    logic [n-1:0] src_b;

    assign Rs1 = in_rs1;
    assign Rs2 = in_rs2;

    // The register file returns the old value on a same-cycle write, hence the bypass.
    assign src_a = (wb_we && wb_rw == in_rs1) ? wb_wdata : Rd1;
    assign src_b = (wb_we && wb_rw == in_rs2) ? wb_wdata : Rd2;

    assign hazard = in_valid && ex_load_pending &&
                    (ex_load_rd == in_rs1 || (ex_load_rd == in_rs2 && !in_use_imm));
    assign in_ready = !hazard && (!valid_q || out_ready);
    assign capture  = in_valid && in_ready;

    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        sdata_d   = sdata_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        use_imm_d = use_imm_q;
        cnt_d     = cnt_q;

        if (capture) begin
            valid_d   = 1'b1;
            a_d       = src_a;
            sdata_d   = src_b;
            b_d       = in_use_imm ? in_imm : src_b;
            op_d      = in_op;
            rd_d      = in_rd;
            rs1_d     = in_rs1;
            rs2_d     = in_rs2;
            use_imm_d = in_use_imm;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q && wb_we) begin
            if (wb_rw == rs1_q) a_d = wb_wdata;
            if (wb_rw == rs2_q) begin
                sdata_d = wb_wdata;
                if (!use_imm_q) b_d = wb_wdata;
            end
        end

        if (hazard && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sdata_q   <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sdata_q   <= sdata_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            use_imm_q <= use_imm_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_sdata = sdata_q;
    assign out_op    = op_q;
    assign out_rd    = rd_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: register-file model, directed scenarios, then random traffic
// checked against a transaction-level reference of the stage.
module tb_operand_fetch_stage;
    localparam int N = 16;
    localparam int A = 3;
    localparam int W = 5;

    logic         Clock = 1'b0;
    logic         nReset;
    logic         in_valid, in_ready, in_use_imm;
    logic [A-1:0] in_rs1, in_rs2, in_rd, Rs1, Rs2, wb_rw, ex_load_rd, out_rd;
    logic [W-1:0] in_op, out_op;
    logic [N-1:0] in_imm, Rd1, Rd2, wb_wdata, out_a, out_b, out_sdata;
    logic         wb_we, ex_load_pending, out_valid, out_ready;
    logic [15:0]  stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0] regs [8];

    // Reference bundle state
    logic         m_valid;
    logic [N-1:0] m_a, m_b, m_sd;
    logic [W-1:0] m_op;
    logic [A-1:0] m_rd, m_rs1, m_rs2;
    logic         m_ui;
    int           m_cnt;
    logic [A+W-1:0] exp_q[$];

    always #5 Clock = ~Clock;

    operand_fetch_stage #(.n(N), .addr_size(A), .opw(W)) dut (
        .Clock(Clock), .nReset(nReset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_op(in_op),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .Rs1(Rs1), .Rs2(Rs2), .Rd1(Rd1), .Rd2(Rd2),
        .wb_we(wb_we), .wb_rw(wb_rw), .wb_wdata(wb_wdata),
        .ex_load_pending(ex_load_pending), .ex_load_rd(ex_load_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_sdata(out_sdata),
        .out_op(out_op), .out_rd(out_rd), .stall_cnt(stall_cnt)
    );

    // Register file: combinational read, write on the clock edge
    assign Rd1 = regs[Rs1];
    assign Rd2 = regs[Rs2];
    always @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[wb_rw] <= wb_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_op = 0; m_rd = 0;
        m_rs1 = 0; m_rs2 = 0; m_ui = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_op = 0; in_imm = 0;
        in_use_imm = 0; wb_we = 0; wb_rw = 0; wb_wdata = 0;
        ex_load_pending = 0; ex_load_rd = 0; out_ready = 1;
    endtask

    task automatic drive_instr(input int rs1, input int rs2, input int rd, input int op,
                               input int imm, input bit ui);
        in_valid = 1; in_rs1 = A'(rs1); in_rs2 = A'(rs2); in_rd = A'(rd);
        in_op = W'(op); in_imm = N'(imm); in_use_imm = ui;
    endtask

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        if (m_valid) begin
            check("out_a", 32'(out_a), 32'(m_a));
            check("out_b", 32'(out_b), 32'(m_b));
            check("out_sdata", 32'(out_sdata), 32'(m_sd));
            check("out_op", 32'(out_op), 32'(m_op));
            check("out_rd", 32'(out_rd), 32'(m_rd));
        end
    endtask

    // One clock: inputs are driven before the call; evaluate at the falling edge, compare after the rising edge.
    task automatic cycle();
        bit hz, rdy;
        logic [N-1:0] sa, sb;
        @(negedge Clock);
        hz  = in_valid && ex_load_pending &&
              (ex_load_rd == in_rs1 || (ex_load_rd == in_rs2 && !in_use_imm));
        rdy = !hz && (!m_valid || out_ready);
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("Rs1", 32'(Rs1), 32'(in_rs1));
        check("Rs2", 32'(Rs2), 32'(in_rs2));
        if (m_valid && out_ready) begin
            if (exp_q.size() == 0) check("consume_unexpected", 32'(1), 32'(0));
            else check("consume_order", 32'({out_rd, out_op}), 32'(exp_q.pop_front()));
        end
        sa = (wb_we && wb_rw == in_rs1) ? wb_wdata : regs[in_rs1];
        sb = (wb_we && wb_rw == in_rs2) ? wb_wdata : regs[in_rs2];
        if (in_valid && rdy) begin
            m_valid = 1; m_a = sa; m_sd = sb; m_b = in_use_imm ? in_imm : sb;
            m_op = in_op; m_rd = in_rd; m_rs1 = in_rs1; m_rs2 = in_rs2; m_ui = in_use_imm;
            exp_q.push_back({in_rd, in_op});
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end else if (m_valid && wb_we) begin
            if (wb_rw == m_rs1) m_a = wb_wdata;
            if (wb_rw == m_rs2) begin
                m_sd = wb_wdata;
                if (!m_ui) m_b = wb_wdata;
            end
        end
        if (hz && m_cnt < 65535) m_cnt++;
        @(posedge Clock);
        #1;
        check_outputs();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 0);
        check({tag, "_a"}, 32'(out_a), 0);
        check({tag, "_b"}, 32'(out_b), 0);
        check({tag, "_sdata"}, 32'(out_sdata), 0);
        check({tag, "_op"}, 32'(out_op), 0);
        check({tag, "_rd"}, 32'(out_rd), 0);
        check({tag, "_cnt"}, 32'(stall_cnt), 0);
    endtask

    initial begin
        drive_idle();
        model_reset();
        nReset = 0;
        #12;
        check_all_zero("reset");
        @(negedge Clock);
        nReset = 1;
        @(posedge Clock); #1;

        // Preload r1, r2
        wb_we = 1; wb_rw = 1; wb_wdata = 16'h1234; cycle();
        wb_rw = 2; wb_wdata = 16'h00FF; cycle();
        wb_we = 0;

        // Simple pass
        drive_instr(1, 2, 4, 3, 0, 0); cycle();
        check("pass_a", 32'(out_a), 32'h1234);
        check("pass_b", 32'(out_b), 32'h00FF);
        check("pass_rd", 32'(out_rd), 4);
        check("pass_op", 32'(out_op), 3);

        // Same-cycle bypass
        drive_instr(1, 0, 6, 7, 0, 0);
        wb_we = 1; wb_rw = 1; wb_wdata = 16'hBEEF; cycle();
        wb_we = 0;
        check("bypass_a", 32'(out_a), 32'hBEEF);

        // Load-use stall for 3 cycles
        drive_instr(0, 2, 3, 9, 0, 0);
        ex_load_pending = 1; ex_load_rd = 2;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_valid", 32'(out_valid), 0);
        end
        check("stall_cnt3", 32'(stall_cnt), 3);
        ex_load_pending = 0; cycle();
        check("release_valid", 32'(out_valid), 1);
        drive_instr(0, 2, 3, 10, 16'h0005, 1);
        ex_load_pending = 1; ex_load_rd = 2; cycle();
        ex_load_pending = 0;
        check("imm_valid", 32'(out_valid), 1);
        check("imm_b", 32'(out_b), 32'h0005);
        check("imm_cnt", 32'(stall_cnt), 3);

        // Backpressure refresh
        drive_instr(5, 6, 1, 11, 0, 0); cycle();
        drive_instr(3, 3, 2, 12, 0, 0);
        out_ready = 0; wb_we = 1; wb_rw = 5; wb_wdata = 16'h7777; cycle();
        check("refresh_a", 32'(out_a), 32'h7777);
        check("refresh_valid", 32'(out_valid), 1);
        check("refresh_rd", 32'(out_rd), 1);
        wb_we = 0; in_valid = 0; out_ready = 1; cycle();
        check("drain_valid", 32'(out_valid), 0);

        // Back-to-back
        for (int i = 0; i < 4; i++) begin
            drive_instr(i, i + 1, i, 20 + i, 0, 0); cycle();
            check("b2b_valid", 32'(out_valid), 1);
            check("b2b_op", 32'(out_op), 32'(20 + i));
        end
        in_valid = 0; cycle();

        // Build up out_valid=1, stall_cnt=7, then reset between edges
        drive_instr(1, 1, 1, 1, 0, 0); cycle();
        out_ready = 0; ex_load_pending = 1; ex_load_rd = 4;
        drive_instr(4, 0, 0, 2, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        check("pre_rst_cnt", 32'(stall_cnt), 7);
        check("pre_rst_valid", 32'(out_valid), 1);
        #2 nReset = 0;
        #1 check_all_zero("midrst");
        drive_idle();
        model_reset();
        @(negedge Clock);
        nReset = 1;
        @(posedge Clock); #1;

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_rs1 = A'($urandom_range(0, 7)); in_rs2 = A'($urandom_range(0, 7));
            in_rd = A'($urandom_range(0, 7)); in_op = W'($urandom);
            in_imm = N'($urandom); in_use_imm = $urandom_range(0, 1) == 1;
            wb_we = $urandom_range(0, 1) == 1; wb_rw = A'($urandom_range(0, 7));
            wb_wdata = N'($urandom);
            ex_load_pending = ($urandom_range(0, 3) == 0);
            ex_load_rd = A'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
